turn_controller: RTL and testbench

TURN_CONTROLLER -- requirements
Module: turn_controller

---
 rtl/go_pkg.sv | 32 +++
 rtl/move_timer.sv | 36 +++
 rtl/turn_controller.sv | 147 ++++++++++++++
 tb/tb_turn_controller.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/go_pkg.sv
// Shared Go turn-controller types: stone codes, reject codes, FSM states, board limits.
// Pure declarations; no latency or backpressure of its own.
package go_pkg;

    typedef enum logic [1:0] {
        STONE_E = 2'b00,
        STONE_B = 2'b01,
        STONE_W = 2'b10
    } stone_t;

    typedef enum logic [1:0] {
        REJ_OK    = 2'b00,
        REJ_RANGE = 2'b01,
        REJ_OCC   = 2'b10
    } rej_t;

    typedef enum logic [1:0] {
        WAIT  = 2'b00,
        CHECK = 2'b01,
        ISSUE = 2'b10,
        OVER  = 2'b11
    } state_t;

    localparam logic [7:0] PASS_MOVE = 8'hFF;
    localparam logic [3:0] BOARD_MAX = 4'd8;

    // 9x9 board: coordinates 0..8 are legal on both axes.
    function automatic logic off_board(input logic [7:0] mv);
        return (mv[7:4] > BOARD_MAX) || (mv[3:0] > BOARD_MAX);
    endfunction

endpackage

// File: rtl/move_timer.sv
// Per-turn move timer; expired is combinational from the count, high at MOVE_TIMEOUT-1 while enabled.
// Clear has priority over enable; no backpressure.
module move_timer #(
    parameter int MOVE_TIMEOUT = 1000,
    parameter int TIMER_W      = 16
) (
    input  logic clk_in,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + TIMER_W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable && (count_q == TIMER_W'(MOVE_TIMEOUT - 1));

endmodule

// File: rtl/turn_controller.sv
// Go turn arbiter: samples the player to move, checks range/occupancy, issues stones; forces passes on timeout.
// Latency: request to move_avail is 2 cycles; requesters hold req until their one-cycle ack.
module turn_controller
    import go_pkg::*;
#(
    parameter int MOVE_TIMEOUT = 1000,
    parameter int TIMER_W      = 16
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       b_req,
    input  logic       w_req,
    input  logic [7:0] b_move,
    input  logic [7:0] w_move,
    input  logic [1:0] rd_data,
    output logic [3:0] rd_row,
    output logic [3:0] rd_col,
    output logic       move_avail,
    output logic [7:0] move,
    output logic [1:0] color,
    output logic       b_ack,
    output logic       w_ack,
    output logic [1:0] rej_code,
    output logic       turn,
    output logic       timeout,
    output logic [7:0] move_count,
    output logic       game_over
);

    state_t     state_q, state_d;
    logic       turn_q, turn_d;
    logic [1:0] pass_cnt_q, pass_cnt_d;
    logic [7:0] move_q, move_d;
    logic [7:0] move_count_q, move_count_d;

    logic       req_sel;
    logic [7:0] move_sel;
    logic       sample, turn_tgl, ack_c, avail_c, timeout_c;
    rej_t       rej_c;
    stone_t     color_c;
    logic       timer_expired;

    assign req_sel  = turn_q ? w_req : b_req;
    assign move_sel = turn_q ? w_move : b_move;

    always_comb begin
        state_d      = state_q;
        pass_cnt_d   = pass_cnt_q;
        move_d       = move_q;
        move_count_d = move_count_q;
        sample       = 1'b0;
        turn_tgl     = 1'b0;
        ack_c        = 1'b0;
        avail_c      = 1'b0;
        timeout_c    = 1'b0;
        rej_c        = REJ_OK;
        color_c      = STONE_E;

        case (state_q)
            WAIT: begin
                // A live request beats a forced pass landing in the same cycle.
                if (req_sel) begin
                    sample  = 1'b1;
                    move_d  = move_sel;
                    state_d = CHECK;
                end else if (timer_expired) begin
                    timeout_c  = 1'b1;
                    turn_tgl   = 1'b1;
                    pass_cnt_d = pass_cnt_q + 2'd1;
                    state_d    = (pass_cnt_q == 2'd1) ? OVER : WAIT;
                end
            end
            CHECK: begin
                ack_c   = 1'b1;
                state_d = WAIT;
                if (move_q == PASS_MOVE) begin
                    turn_tgl   = 1'b1;
                    pass_cnt_d = pass_cnt_q + 2'd1;
                    state_d    = (pass_cnt_q == 2'd1) ? OVER : WAIT;
                end else if (off_board(move_q)) begin
                    rej_c = REJ_RANGE;
                end else if (rd_data != STONE_E) begin
                    rej_c = REJ_OCC;
                end else begin
                    ack_c   = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                avail_c      = 1'b1;
                ack_c        = 1'b1;
                color_c      = turn_q ? STONE_W : STONE_B;
                pass_cnt_d   = 2'd0;
                move_count_d = (move_count_q == 8'hFF) ? move_count_q : move_count_q + 8'd1;
                turn_tgl     = 1'b1;
                state_d      = WAIT;
            end
            default: begin
                state_d = OVER;
            end
        endcase

        turn_d = turn_q ^ turn_tgl;
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q      <= WAIT;
            turn_q       <= 1'b0;
            pass_cnt_q   <= 2'd0;
            move_q       <= 8'h00;
            move_count_q <= 8'h00;
        end else begin
            state_q      <= state_d;
            turn_q       <= turn_d;
            pass_cnt_q   <= pass_cnt_d;
            move_q       <= move_d;
            move_count_q <= move_count_d;
        end
    end

    move_timer #(
        .MOVE_TIMEOUT (MOVE_TIMEOUT),
        .TIMER_W      (TIMER_W)
    ) u_move_timer (
        .clk_in  (clk_in),
        .reset   (reset),
        .clear   ((state_q != WAIT) || sample || turn_tgl),
        .enable  (state_q == WAIT),
        .expired (timer_expired)
    );

    // Strobes are masked during reset so an aborted CHECK/ISSUE never leaks out.
    assign move_avail = avail_c & ~reset;
    assign b_ack      = ack_c & ~turn_q & ~reset;
    assign w_ack      = ack_c & turn_q & ~reset;
    assign timeout    = timeout_c & ~reset;
    assign rej_code   = reset ? REJ_OK : rej_c;
    assign color      = reset ? STONE_E : color_c;
    assign move       = move_q;
    assign rd_row     = move_q[7:4];
    assign rd_col     = move_q[3:0];
    assign turn       = turn_q;
    assign move_count = move_count_q;
    assign game_over  = (state_q == OVER);

endmodule

// File: tb/tb_turn_controller.sv
// Directed bench for turn_controller with a short move timeout.
module tb_turn_controller;

    logic       clk_in = 1'b0;
    logic       reset  = 1'b1;
    logic       b_req, w_req;
    logic [7:0] b_move, w_move;
    logic [1:0] rd_data;
    logic [3:0] rd_row, rd_col;
    logic       move_avail, b_ack, w_ack, turn, timeout, game_over;
    logic [7:0] move, move_count;
    logic [1:0] color, rej_code;

    always #5 clk_in = ~clk_in;

    turn_controller #(
        .MOVE_TIMEOUT (8),
        .TIMER_W      (16)
    ) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .b_req      (b_req),
        .w_req      (w_req),
        .b_move     (b_move),
        .w_move     (w_move),
        .rd_data    (rd_data),
        .rd_row     (rd_row),
        .rd_col     (rd_col),
        .move_avail (move_avail),
        .move       (move),
        .color      (color),
        .b_ack      (b_ack),
        .w_ack      (w_ack),
        .rej_code   (rej_code),
        .turn       (turn),
        .timeout    (timeout),
        .move_count (move_count),
        .game_over  (game_over)
    );

    typedef struct packed {
        logic       br;
        logic       wr;
        logic [7:0] bm;
        logic [7:0] wm;
        logic [1:0] rd;
        logic       ma;
        logic [7:0] mv;
        logic [1:0] col;
        logic       ba;
        logic       wa;
        logic [1:0] rc;
        logic       trn;
        logic       to;
        logic       go;
        logic [7:0] mc;
    } vec_t;

    localparam int NV = 31;
    vec_t tbl [NV];

    int n_vec = 0;
    int n_err = 0;

    logic [33:0] obs;
    assign obs = {move_avail, move, rd_row, rd_col, color, b_ack, w_ack,
                  rej_code, turn, timeout, game_over, move_count};

    function automatic vec_t mkv(input int br, input int wr, input int bm, input int wm,
                                 input int rd, input int ma, input int mv, input int col,
                                 input int ba, input int wa, input int rc, input int trn,
                                 input int to, input int go, input int mc);
        vec_t v;
        v.br  = 1'(br);  v.wr = 1'(wr);  v.bm  = 8'(bm); v.wm = 8'(wm);
        v.rd  = 2'(rd);  v.ma = 1'(ma);  v.mv  = 8'(mv); v.col = 2'(col);
        v.ba  = 1'(ba);  v.wa = 1'(wa);  v.rc  = 2'(rc); v.trn = 1'(trn);
        v.to  = 1'(to);  v.go = 1'(go);  v.mc  = 8'(mc);
        return v;
    endfunction

    task automatic check(input string nm, input logic [33:0] act, input logic [33:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        b_req  = 1'b0;
        w_req  = 1'b0;
        b_move = 8'h00;
        w_move = 8'h00;
        rd_data = 2'b00;
        next_cycle();
        next_cycle();
        @(negedge clk_in);
        check("reset_state", obs, 34'd0);
        next_cycle();
        reset = 1'b0;
    endtask

    initial begin
        //              br wr bm     wm     rd  ma mv     col ba wa rc trn to go mc
        tbl[0]  = mkv(0, 0, 'h00, 'h00, 0,  0, 'h00, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mkv(0, 1, 'h00, 'h55, 0,  0, 'h00, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mkv(1, 1, 'h44, 'h55, 0,  0, 'h00, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mkv(1, 1, 'h44, 'h55, 0,  0, 'h44, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[4]  = mkv(1, 1, 'h44, 'h55, 0,  1, 'h44, 1, 1, 0, 0, 0, 0, 0, 0);
        tbl[5]  = mkv(0, 1, 'h00, 'h55, 0,  0, 'h44, 0, 0, 0, 0, 1, 0, 0, 1);
        tbl[6]  = mkv(0, 1, 'h00, 'h55, 0,  0, 'h55, 0, 0, 0, 0, 1, 0, 0, 1);
        tbl[7]  = mkv(0, 1, 'h00, 'h55, 0,  1, 'h55, 2, 0, 1, 0, 1, 0, 0, 1);
        tbl[8]  = mkv(1, 0, 'h9A, 'h00, 0,  0, 'h55, 0, 0, 0, 0, 0, 0, 0, 2);
        tbl[9]  = mkv(1, 0, 'h9A, 'h00, 0,  0, 'h9A, 0, 1, 0, 1, 0, 0, 0, 2);
        tbl[10] = mkv(0, 0, 'h00, 'h00, 0,  0, 'h9A, 0, 0, 0, 0, 0, 0, 0, 2);
        tbl[11] = mkv(1, 0, 'h33, 'h00, 1,  0, 'h9A, 0, 0, 0, 0, 0, 0, 0, 2);
        tbl[12] = mkv(1, 0, 'h33, 'h00, 1,  0, 'h33, 0, 1, 0, 2, 0, 0, 0, 2);
        tbl[13] = mkv(0, 0, 'h00, 'h00, 0,  0, 'h33, 0, 0, 0, 0, 0, 0, 0, 2);
        tbl[14] = mkv(1, 0, 'h49, 'h00, 0,  0, 'h33, 0, 0, 0, 0, 0, 0, 0, 2);
        tbl[15] = mkv(1, 0, 'h49, 'h00, 0,  0, 'h49, 0, 1, 0, 1, 0, 0, 0, 2);
        tbl[16] = mkv(0, 0, 'h00, 'h00, 0,  0, 'h49, 0, 0, 0, 0, 0, 0, 0, 2);
        tbl[17] = mkv(1, 0, 'h88, 'h00, 0,  0, 'h49, 0, 0, 0, 0, 0, 0, 0, 2);
        tbl[18] = mkv(1, 0, 'h88, 'h00, 0,  0, 'h88, 0, 0, 0, 0, 0, 0, 0, 2);
        tbl[19] = mkv(1, 0, 'h88, 'h00, 0,  1, 'h88, 1, 1, 0, 0, 0, 0, 0, 2);
        tbl[20] = mkv(0, 1, 'h00, 'hFF, 0,  0, 'h88, 0, 0, 0, 0, 1, 0, 0, 3);
        tbl[21] = mkv(0, 1, 'h00, 'hFF, 0,  0, 'hFF, 0, 0, 1, 0, 1, 0, 0, 3);
        tbl[22] = mkv(1, 0, 'h12, 'h00, 0,  0, 'hFF, 0, 0, 0, 0, 0, 0, 0, 3);
        tbl[23] = mkv(1, 0, 'h12, 'h00, 0,  0, 'h12, 0, 0, 0, 0, 0, 0, 0, 3);
        tbl[24] = mkv(1, 0, 'h12, 'h00, 0,  1, 'h12, 1, 1, 0, 0, 0, 0, 0, 3);
        tbl[25] = mkv(0, 1, 'h00, 'hFF, 0,  0, 'h12, 0, 0, 0, 0, 1, 0, 0, 4);
        tbl[26] = mkv(0, 1, 'h00, 'hFF, 0,  0, 'hFF, 0, 0, 1, 0, 1, 0, 0, 4);
        tbl[27] = mkv(1, 0, 'hFF, 'h00, 0,  0, 'hFF, 0, 0, 0, 0, 0, 0, 0, 4);
        tbl[28] = mkv(1, 0, 'hFF, 'h00, 0,  0, 'hFF, 0, 1, 0, 0, 0, 0, 0, 4);
        tbl[29] = mkv(0, 1, 'h00, 'h22, 0,  0, 'hFF, 0, 0, 0, 0, 1, 0, 1, 4);
        tbl[30] = mkv(1, 1, 'h22, 'h22, 0,  0, 'hFF, 0, 0, 0, 0, 1, 0, 1, 4);

        do_reset();
        for (int i = 0; i < NV; i++) begin
            b_req   = tbl[i].br;
            w_req   = tbl[i].wr;
            b_move  = tbl[i].bm;
            w_move  = tbl[i].wm;
            rd_data = tbl[i].rd;
            @(negedge clk_in);
            check($sformatf("vec%0d", i), obs,
                  {tbl[i].ma, tbl[i].mv, tbl[i].mv, tbl[i].col, tbl[i].ba, tbl[i].wa,
                   tbl[i].rc, tbl[i].trn, tbl[i].to, tbl[i].go, tbl[i].mc});
            next_cycle();
        end

        // Idle board: forced pass on the 8th WAIT cycle of each turn, game over after two.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            @(negedge clk_in);
            check($sformatf("timeout_cyc%0d", i), 34'({timeout, turn, game_over}),
                  34'({(i == 7) || (i == 15), (i >= 8) && (i < 16), i == 16}));
            next_cycle();
        end

        // Request arriving exactly when the timer expires wins over the forced pass.
        do_reset();
        repeat (7) next_cycle();
        b_req  = 1'b1;
        b_move = 8'h44;
        @(negedge clk_in);
        check("race_no_timeout", 34'({timeout, turn, b_ack}), 34'd0);
        next_cycle();
        next_cycle();
        @(negedge clk_in);
        check("race_issue", 34'({move_avail, b_ack, color, move}), 34'({1'b1, 1'b1, 2'b01, 8'h44}));
        next_cycle();
        b_req = 1'b0;
        @(negedge clk_in);
        check("race_turn", 34'({turn, timeout, move_count}), 34'({1'b1, 1'b0, 8'd1}));

        // Reset landing on the ISSUE cycle aborts the move.
        do_reset();
        b_req  = 1'b1;
        b_move = 8'h44;
        next_cycle();
        next_cycle();
        reset = 1'b1;
        @(negedge clk_in);
        check("rst_issue_now", 34'({move_avail, b_ack}), 34'd0);
        next_cycle();
        reset = 1'b0;
        b_req = 1'b0;
        @(negedge clk_in);
        check("rst_issue_after", 34'({move_avail, b_ack, w_ack, turn, move_count, game_over}), 34'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
